// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between CPU and loader ports, with
// optional locked bursts (up to MAX_BURST grants) and registered read return.
module dmem_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_BURST     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic                     lock0,
    input  logic                     lock1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata0,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             own_req;
    logic             own_lock;

    assign own_req  = owner ? req1 : req0;
    assign own_lock = owner ? lock1 : lock0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant selection, burst tracking and memory-port mux.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;

        case (state)
            ARB: begin
                if (req0 && (!req1 || last)) begin
                    gnt0     = 1'b1;
                    last_nxt = 1'b0;
                    if (lock0) begin
                        state_nxt = LOCKED;
                        owner_nxt = 1'b0;
                        cnt_nxt   = CNT_W'(1);
                    end
                end else if (req1) begin
                    gnt1     = 1'b1;
                    last_nxt = 1'b1;
                    if (lock1) begin
                        state_nxt = LOCKED;
                        owner_nxt = 1'b1;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Leaving with last = owner hands the next contention to the other port.
                last_nxt = owner;
                if (own_req) begin
                    gnt0    = ~owner;
                    gnt1    = owner;
                    cnt_nxt = cnt + CNT_W'(1);
                end
                if (!own_req || !own_lock || (cnt_nxt >= CNT_W'(MAX_BURST))) begin
                    state_nxt = ARB;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ARB;
        endcase

        if (gnt0) begin
            mem_we = we0;
            mem_a  = addr0;
            mem_wd = wdata0;
        end else if (gnt1) begin
            mem_we = we1;
            mem_a  = addr1;
            mem_wd = wdata1;
        end
    end

    // Read return: one-cycle rvalid pulse, rdata held until the port's next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= mem_rd;
            if (gnt1 && !we1) rdata1 <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a burst-level arbitration model.
module tb_dmem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int          MAXB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
    logic [AW-1:0] mem_a;

    logic [DW-1:0] tbmem [0:255];

    int checks = 0;
    int errors = 0;

    // Model: owner of the current burst (-1 when arbitrating), grants in burst, last served.
    int            m_owner;
    int            m_burst;
    int            m_last;
    logic          exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rd0, exp_rd1;
    bit            model_on = 1'b0;
    int            pg, cg;

    always #5 clk = ~clk;

    assign mem_rd = tbmem[mem_a[7:0]];

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mgrant();
        if (m_owner >= 0)
            return ((m_owner == 0) ? req0 : req1) ? m_owner : -1;
        if (req0 && req1) return 1 - m_last;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    // Reference update at each active edge.
    always @(posedge clk) begin
        pg = mgrant();
        if (pg == 0 && we0) tbmem[addr0[7:0]] <= wdata0;
        if (pg == 1 && we1) tbmem[addr1[7:0]] <= wdata1;
        if (rst) begin
            m_owner  = -1;
            m_burst  = 0;
            m_last   = 1;
            exp_rv0  = 1'b0;
            exp_rv1  = 1'b0;
            exp_rd0  = '0;
            exp_rd1  = '0;
            model_on = 1'b1;
        end else begin
            exp_rv0 = (pg == 0) && !we0;
            exp_rv1 = (pg == 1) && !we1;
            if (exp_rv0) exp_rd0 = tbmem[addr0[7:0]];
            if (exp_rv1) exp_rd1 = tbmem[addr1[7:0]];
            if (m_owner >= 0) begin
                m_last = m_owner;
                if (pg >= 0) m_burst++;
                if (pg < 0 || !((m_owner == 0) ? lock0 : lock1) || m_burst >= MAXB) begin
                    m_owner = -1;
                    m_burst = 0;
                end
            end else if (pg >= 0) begin
                m_last = pg;
                if ((pg == 0) ? lock0 : lock1) begin
                    m_owner = pg;
                    m_burst = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            cg = mgrant();
            chk("gnt0", 32'(gnt0), 32'(cg == 0));
            chk("gnt1", 32'(gnt1), 32'(cg == 1));
            chk("mem_we", 32'(mem_we), (cg == 0) ? 32'(we0) : (cg == 1) ? 32'(we1) : 32'd0);
            chk("mem_a", mem_a, (cg == 0) ? addr0 : (cg == 1) ? addr1 : 32'd0);
            chk("mem_wd", mem_wd, (cg == 0) ? wdata0 : (cg == 1) ? wdata1 : 32'd0);
            chk("rvalid0", 32'(rvalid0), 32'(exp_rv0));
            chk("rvalid1", 32'(rvalid1), 32'(exp_rv1));
            chk("rdata0", rdata0, exp_rd0);
            chk("rdata1", rdata1, exp_rd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = 32'hA500_0000 + 32'(i);
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        rst = 1'b0;

        // Contended reads alternate starting with port 0.
        for (int i = 0; i < 4; i++) begin
            req0 = 1; req1 = 1; addr0 = 32'h08; addr1 = 32'h09;
            #2;
            chk("alt_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            chk("alt_gnt1", 32'(gnt1), 32'(i % 2 == 1));
            step();
            if (i % 2 == 0) begin
                chk("alt_rvalid0", 32'(rvalid0), 32'd1);
                chk("alt_rdata0", rdata0, 32'hA500_0008);
            end else begin
                chk("alt_rvalid1", 32'(rvalid1), 32'd1);
                chk("alt_rdata1", rdata1, 32'hA500_0009);
            end
        end
        idle(); req0 = 1; addr0 = 32'h08;
        step();

        // Locked write burst capped at MAX_BURST, then port 0 slips in once.
        for (int i = 0; i < 12; i++) begin
            idle();
            req1 = 1; lock1 = 1; we1 = 1; addr1 = 32'h10 + 32'(4 * (i % 8)); wdata1 = 32'h1000 + 32'(i);
            req0 = 1; addr0 = 32'h08;
            #2;
            chk("cap_gnt1", 32'(gnt1), 32'((i < 8) || (i >= 9)));
            chk("cap_gnt0", 32'(gnt0), 32'(i == 8));
            step();
        end
        idle();
        step();
        req0 = 1; addr0 = 32'h08;
        step();

        // Port 1 drops lock on its third grant; port 0 gets the fourth cycle.
        for (int i = 0; i < 5; i++) begin
            idle();
            req0 = 1; addr0 = 32'h08;
            req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'h55; lock1 = (i < 2);
            #2;
            chk("unlock_gnt0", 32'(gnt0), 32'(i == 3));
            chk("unlock_gnt1", 32'(gnt1), 32'(i != 3));
            step();
        end

        // Write then read back the same word.
        idle(); req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'hDEAD_BEEF;
        #2;
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_a", mem_a, 32'h40);
        chk("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
        step();
        we0 = 0;
        #2;
        chk("wr_no_rvalid0", 32'(rvalid0), 32'd0);
        step();
        idle();
        #2;
        chk("rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        step();

        // Reset in the third cycle of a port 1 burst.
        for (int i = 0; i < 3; i++) begin
            idle();
            req0 = 1; addr0 = 32'h08;
            req1 = 1; lock1 = 1; addr1 = 32'h11;
            rst = (i == 2);
            #2;
            chk("rstb_gnt1", 32'(gnt1), 32'd1);
            step();
        end
        rst = 1'b0;
        chk("rstb_rvalid0", 32'(rvalid0), 32'd0);
        chk("rstb_rvalid1", 32'(rvalid1), 32'd0);
        chk("rstb_rdata1", rdata1, 32'd0);
        #2;
        chk("rstb_gnt0", 32'(gnt0), 32'd1);
        step();
        idle();

        // Idle cycles keep outputs quiet and read data held.
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
            chk("idle_mem_we", 32'(mem_we), 32'd0);
            chk("idle_mem_a", mem_a, 32'd0);
            step();
            chk("idle_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
            chk("idle_rdata0", rdata0, 32'hA500_0008);
            chk("idle_rdata1", rdata1, 32'd0);
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 199) == 0);
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 3) != 0);
            we0    = $urandom_range(0, 1) == 1;
            we1    = $urandom_range(0, 1) == 1;
            lock0  = ($urandom_range(0, 2) == 0);
            lock1  = ($urandom_range(0, 1) == 1);
            addr0  = 32'($urandom_range(0, 255));
            addr1  = 32'($urandom_range(0, 255));
            wdata0 = $urandom;
            wdata1 = $urandom;
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
